bus_arbiter_2: RTL and testbench

Two-host arbiter sitting directly upstream of the bus hub. It merges two bus hosts (e.g. instruction fetch and load/store) onto the single host port of the hub. A registered grant FSM owns the shared port for one complete transaction. A timeout watchdog completes transactions to stalled devices with an error.

---
 rtl/bus_arbiter_2.sv | 214 +++++++++++++++++++++
 tb/tb_bus_arbiter_2.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_2.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2
// Two-host arbiter that merges two bus hosts (for example instruction fetch
// and load/store) onto the single host port of the downstream bus hub.
// A grant FSM (IDLE / GRANT0 / GRANT1) owns the shared port for exactly one
// transaction. A wait-state watchdog ends transactions to stalled devices with
// an error response.
//
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests alternate, using the last granted host
//   undefined : fixed priority, host 0 always wins simultaneous requests
//
// Parameters:
//   TIMEOUT_CYCLES : grant cycles without bus_ready before forced completion
//                    (0 disables the watchdog)
//   TIMEOUT_DATA   : read data returned to the host on a timeout
//
// Ports:
//   clk, rst                 : clock (rising edge), async active-high reset
//   m0_* / m1_*              : host ports (address, write data, byte mask,
//                              ren, wen in; read data, ready, error out)
//   bus_*                    : hub host port (address, write data, mask,
//                              ren, wen out; read data, ready in)
// -----------------------------------------------------------------------------
module bus_arbiter_2 #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data_write,
    input  logic [3:0]  m0_write_mask,
    input  logic        m0_ren,
    input  logic        m0_wen,
    output logic [31:0] m0_data_read,
    output logic        m0_ready,
    output logic        m0_error,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data_write,
    input  logic [3:0]  m1_write_mask,
    input  logic        m1_ren,
    input  logic        m1_wen,
    output logic [31:0] m1_data_read,
    output logic        m1_ready,
    output logic        m1_error,
    output logic [31:0] bus_address,
    output logic [31:0] bus_data_write,
    output logic [3:0]  bus_write_mask,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [31:0] bus_data_read,
    input  logic        bus_ready
);

    // Wait counter is at least one bit wide even when the watchdog is off.
    localparam int              CNT_W     = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam bit               WD_EN     = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             req0_s;
    logic             req1_s;
    logic             gnt_req_s;
    logic             timeout_s;
    logic             done_s;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // Only the round-robin build needs to remember who was served last.
    logic             last_grant_r;
    logic             last_grant_nxt_s;
`endif

    assign req0_s = m0_ren | m0_wen;
    assign req1_s = m1_ren | m1_wen;

    // Request of the granted host, watchdog expiry and normal completion.
    always_comb begin
        gnt_req_s = 1'b0;
        case (state_r)
            ST_GRANT0: gnt_req_s = req0_s;
            ST_GRANT1: gnt_req_s = req1_s;
            default:   gnt_req_s = 1'b0;
        endcase
        // Timeout takes precedence over a bus_ready arriving in the same cycle.
        if (WD_EN && (state_r != ST_IDLE) && gnt_req_s && (cnt_r == CNT_LIMIT)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        done_s = (state_r != ST_IDLE) && gnt_req_s && bus_ready && !timeout_s;
    end

    // State, wait counter and last-grant registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_grant_r <= 1'b1;
`endif
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_grant_r <= last_grant_nxt_s;
`endif
        end
    end

    // Next-state logic: arbitration in IDLE, completion/drop/timeout in GRANTx.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        last_grant_nxt_s = last_grant_r;
`endif
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (req0_s && req1_s) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    state_nxt_s = last_grant_r ? ST_GRANT0 : ST_GRANT1;
`else
                    state_nxt_s = ST_GRANT0;
`endif
                end else if (req0_s) begin
                    state_nxt_s = ST_GRANT0;
                end else if (req1_s) begin
                    state_nxt_s = ST_GRANT1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!gnt_req_s) begin
                    // Host withdrew its request: abandon silently.
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (timeout_s || done_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    last_grant_nxt_s = (state_r == ST_GRANT1);
`endif
                end else begin
                    state_nxt_s = state_r;
                    // Saturate rather than wrap so a disabled watchdog stays quiet.
                    if (cnt_r != CNT_MAX) begin
                        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output logic: forward the granted host, answer it, silence the other.
    always_comb begin
        bus_address    = 32'h0000_0000;
        bus_data_write = 32'h0000_0000;
        bus_write_mask = 4'b0000;
        bus_ren        = 1'b0;
        bus_wen        = 1'b0;
        m0_data_read   = 32'h0000_0000;
        m0_ready       = 1'b0;
        m0_error       = 1'b0;
        m1_data_read   = 32'h0000_0000;
        m1_ready       = 1'b0;
        m1_error       = 1'b0;
        case (state_r)
            ST_GRANT0: begin
                bus_address    = m0_address;
                bus_data_write = m0_data_write;
                bus_write_mask = m0_write_mask;
                bus_ren        = m0_ren & ~timeout_s;
                bus_wen        = m0_wen & ~timeout_s;
                m0_ready       = done_s | timeout_s;
                m0_error       = timeout_s;
                m0_data_read   = timeout_s ? TIMEOUT_DATA : bus_data_read;
            end
            ST_GRANT1: begin
                bus_address    = m1_address;
                bus_data_write = m1_data_write;
                bus_write_mask = m1_write_mask;
                bus_ren        = m1_ren & ~timeout_s;
                bus_wen        = m1_wen & ~timeout_s;
                m1_ready       = done_s | timeout_s;
                m1_error       = timeout_s;
                m1_data_read   = timeout_s ? TIMEOUT_DATA : bus_data_read;
            end
            default: begin
                bus_ren = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_2.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_2
// Table-driven bench for bus_arbiter_2 (TIMEOUT_CYCLES = 4). Each table row is
// one clock cycle: host/bus inputs plus the hand-computed output image of that
// cycle. A short hand-written sequence covers asynchronous mid-transaction reset.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_2;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] D0 = 32'h1111_2222;
    localparam logic [3:0]  K0 = 4'b1111;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] D1 = 32'hCAFE_F00D;
    localparam logic [3:0]  K1 = 4'b0011;
    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;

    // Second grant of each contention pair depends on the arbitration policy.
`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam int G_B = 2;
`else
    localparam int G_B = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_address = A0, m0_data_write = D0;
    logic [3:0]  m0_write_mask = K0;
    logic        m0_ren = 1'b0, m0_wen = 1'b0;
    logic [31:0] m0_data_read;
    logic        m0_ready, m0_error;
    logic [31:0] m1_address = A1, m1_data_write = D1;
    logic [3:0]  m1_write_mask = K1;
    logic        m1_ren = 1'b0, m1_wen = 1'b0;
    logic [31:0] m1_data_read;
    logic        m1_ready, m1_error;
    logic [31:0] bus_address, bus_data_write;
    logic [3:0]  bus_write_mask;
    logic        bus_ren, bus_wen;
    logic [31:0] bus_data_read = 32'h0;
    logic        bus_ready = 1'b0;

    logic [137:0] act;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string        nm;
        logic         r0, w0, r1, w1, rdy;
        logic [31:0]  rd;
        logic [137:0] exp;
    } vec_t;

    vec_t tbl[$];

    bus_arbiter_2 #(.TIMEOUT_CYCLES(4), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_data_write(m0_data_write), .m0_write_mask(m0_write_mask),
        .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_data_read(m0_data_read),
        .m0_ready(m0_ready), .m0_error(m0_error),
        .m1_address(m1_address), .m1_data_write(m1_data_write), .m1_write_mask(m1_write_mask),
        .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_data_read(m1_data_read),
        .m1_ready(m1_ready), .m1_error(m1_error),
        .bus_address(bus_address), .bus_data_write(bus_data_write), .bus_write_mask(bus_write_mask),
        .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_data_read(bus_data_read), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    assign act = {bus_ren, bus_wen, bus_address, bus_data_write, bus_write_mask,
                  m0_ready, m0_error, m0_data_read, m1_ready, m1_error, m1_data_read};

    // g: 0 = idle (all outputs zero), 1 = host 0 granted, 2 = host 1 granted.
    function automatic vec_t mk(string nm, logic r0, logic w0, logic r1, logic w1,
                                logic rdy, logic [31:0] rd, int g,
                                logic e_ren, logic e_wen, logic e_rdy, logic e_err,
                                logic [31:0] e_rd);
        vec_t v;
        v.nm = nm; v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.rdy = rdy; v.rd = rd;
        if (g == 1)
            v.exp = {e_ren, e_wen, A0, D0, K0, e_rdy, e_err, e_rd, L, L, 32'h0};
        else if (g == 2)
            v.exp = {e_ren, e_wen, A1, D1, K1, L, L, 32'h0, e_rdy, e_err, e_rd};
        else
            v.exp = '0;
        return v;
    endfunction

    function automatic vec_t idle(string nm, logic r0, logic w0, logic r1, logic w1,
                                  logic rdy, logic [31:0] rd);
        return mk(nm, r0, w0, r1, w1, rdy, rd, 0, L, L, L, L, 32'h0);
    endfunction

    task automatic chk(string nm, logic [137:0] a, logic [137:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    initial begin
        vec_t t;
        // Contention: host 0 reads, host 1 writes, device always ready.
        tbl.push_back(idle("cont_idle0", H, L, L, H, H, 32'hA5A5_0001));
        tbl.push_back(mk("cont_gA0", H, L, L, H, H, 32'hA5A5_0001, 1, H, L, H, L, 32'hA5A5_0001));
        tbl.push_back(idle("cont_idle1", H, L, L, H, H, 32'hA5A5_0001));
        tbl.push_back(mk("cont_gB0", H, L, L, H, H, 32'hA5A5_0001, G_B, (G_B == 1), (G_B == 2), H, L, 32'hA5A5_0001));
        tbl.push_back(idle("cont_idle2", H, L, L, H, H, 32'hA5A5_0001));
        tbl.push_back(mk("cont_gA1", H, L, L, H, H, 32'hA5A5_0001, 1, H, L, H, L, 32'hA5A5_0001));
        tbl.push_back(idle("cont_idle3", H, L, L, H, H, 32'hA5A5_0001));
        tbl.push_back(mk("cont_gB1", H, L, L, H, H, 32'hA5A5_0001, G_B, (G_B == 1), (G_B == 2), H, L, 32'hA5A5_0001));
        tbl.push_back(idle("cont_end", L, L, L, L, L, 32'h0));
        // Single read by host 0.
        tbl.push_back(idle("rd_idle", H, L, L, L, H, 32'h1234_5678));
        tbl.push_back(mk("rd_grant", H, L, L, L, H, 32'h1234_5678, 1, H, L, H, L, 32'h1234_5678));
        tbl.push_back(idle("rd_after", L, L, L, L, H, 32'h0000_0055));
        // Host 1 write with three wait states.
        tbl.push_back(idle("ws_idle", L, L, L, H, L, 32'h0BAD_0001));
        tbl.push_back(mk("ws_wait1", L, L, L, H, L, 32'h0BAD_0001, 2, L, H, L, L, 32'h0BAD_0001));
        tbl.push_back(mk("ws_wait2", L, L, L, H, L, 32'h0BAD_0001, 2, L, H, L, L, 32'h0BAD_0001));
        tbl.push_back(mk("ws_wait3", L, L, L, H, L, 32'h0BAD_0001, 2, L, H, L, L, 32'h0BAD_0001));
        tbl.push_back(mk("ws_done", L, L, L, H, H, 32'h0BAD_0001, 2, L, H, H, L, 32'h0BAD_0001));
        tbl.push_back(idle("ws_after", L, L, L, L, L, 32'h0));
        // Host 0 drops its request after two wait cycles.
        tbl.push_back(idle("dr_idle", H, L, L, L, L, 32'h0000_D00D));
        tbl.push_back(mk("dr_wait1", H, L, L, L, L, 32'h0000_D00D, 1, H, L, L, L, 32'h0000_D00D));
        tbl.push_back(mk("dr_wait2", H, L, L, L, L, 32'h0000_D00D, 1, H, L, L, L, 32'h0000_D00D));
        tbl.push_back(mk("dr_drop", L, L, L, L, L, 32'h0000_D00D, 1, L, L, L, L, 32'h0000_D00D));
        tbl.push_back(idle("dr_after", L, L, L, L, L, 32'h0000_D00D));
        // Timeout: four wait cycles, forced completion on the fifth.
        tbl.push_back(idle("to_idle", H, L, L, L, L, 32'h7777_7777));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk($sformatf("to_wait%0d", i), H, L, L, L, L, 32'h7777_7777, 1, H, L, L, L, 32'h7777_7777));
        tbl.push_back(mk("to_fire", H, L, L, L, L, 32'h7777_7777, 1, L, L, H, H, 32'hDEAD_BEEF));
        tbl.push_back(idle("to_after", L, L, L, L, L, 32'h7777_7777));
        // Timeout wins over a bus_ready in the same cycle.
        tbl.push_back(idle("tr_idle", H, L, L, L, L, 32'h6666_6666));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk($sformatf("tr_wait%0d", i), H, L, L, L, L, 32'h6666_6666, 1, H, L, L, L, 32'h6666_6666));
        tbl.push_back(mk("tr_fire", H, L, L, L, H, 32'h6666_6666, 1, L, L, H, H, 32'hDEAD_BEEF));
        tbl.push_back(idle("tr_after", L, L, L, L, H, 32'h6666_6666));

        // Reset held with live requests: every output must be 0.
        m0_ren = 1'b1; bus_ready = 1'b1; bus_data_read = 32'h1357_9BDF;
        #2;
        chk("reset", act, '0);
        @(negedge clk);
        rst = 1'b0; m0_ren = 1'b0; bus_ready = 1'b0; bus_data_read = 32'h0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            m0_ren = tbl[i].r0; m0_wen = tbl[i].w0;
            m1_ren = tbl[i].r1; m1_wen = tbl[i].w1;
            bus_ready = tbl[i].rdy; bus_data_read = tbl[i].rd;
            #1;
            chk(tbl[i].nm, act, tbl[i].exp);
        end

        // Reset pulsed mid-cycle while host 1 is waiting on the device.
        @(negedge clk);
        m0_ren = 1'b0; m0_wen = 1'b0; m1_ren = 1'b0; m1_wen = 1'b1;
        bus_ready = 1'b0; bus_data_read = 32'h0;
        @(negedge clk);
        #1;
        t = mk("rst_pre", L, L, L, H, L, 32'h0, 2, L, H, L, L, 32'h0);
        chk(t.nm, act, t.exp);
        rst = 1'b1;
        #1;
        chk("rst_async", act, '0);
        #1;
        rst = 1'b0; m1_wen = 1'b0; m0_ren = 1'b1;
        #1;
        chk("rst_idle", act, '0);
        @(negedge clk);
        #1;
        t = mk("rst_regrant", H, L, L, L, L, 32'h0, 1, H, L, L, L, 32'h0);
        chk(t.nm, act, t.exp);
        m0_ren = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
